// File: rtl/p2s_serializer.sv
// Parallel-to-serial stage feeding the sequence detector: WIDTH-bit words in over valid/ready, one bit per clock out.
// Optional even-parity trailer bit per word is enabled by defining P2S_PARITY_EN.
module p2s_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             stall,
  output logic             data,
  output logic             data_valid,
  output logic             busy
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef P2S_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
`ifdef P2S_PARITY_EN
  logic             par;
`endif

  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;
  logic             last_slot;
  logic             accept;

  assign next_bit      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // The slot in which the final bit of a word leaves is also the slot in which the next word may load.
`ifdef P2S_PARITY_EN
  assign last_slot = (state == PARITY) && !stall;
`else
  assign last_slot = (state == SHIFT) && (cnt == LAST) && !stall;
`endif

  assign din_ready = (state == IDLE) || last_slot;
  assign accept    = din_valid && din_ready;
  assign busy      = (state != IDLE);

  // NOTE: all state here is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      data       <= 1'b0;
      data_valid <= 1'b0;
`ifdef P2S_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          data_valid <= 1'b0;
          if (accept) begin
            shreg <= din;
            cnt   <= '0;
            state <= SHIFT;
`ifdef P2S_PARITY_EN
            par   <= ^din;
`endif
          end
        end

        SHIFT: begin
          if (stall) begin
            data_valid <= 1'b0;
          end else begin
            data       <= next_bit;
            data_valid <= 1'b1;
            shreg      <= shreg_shifted;
            if (cnt == LAST) begin
              cnt <= '0;
`ifdef P2S_PARITY_EN
              state <= PARITY;
`else
              if (accept) begin
                shreg <= din;
                state <= SHIFT;
              end else begin
                state <= IDLE;
              end
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

`ifdef P2S_PARITY_EN
        PARITY: begin
          if (stall) begin
            data_valid <= 1'b0;
          end else begin
            data       <= par;
            data_valid <= 1'b1;
            if (accept) begin
              shreg <= din;
              cnt   <= '0;
              par   <= ^din;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_serializer.sv
// Self-checking bench for p2s_serializer: queue-based bit-stream model, directed literal cases and random traffic.
// Two instances (MSB-first and LSB-first) share the same stimulus.
module tb_p2s_serializer;

  localparam int W = 8;
`ifdef P2S_PARITY_EN
  localparam int NB = W + 1;
  localparam logic [31:0] E_B6  = 32'h16D;
  localparam logic [31:0] E_B2B = 32'hD9E0;
  localparam logic [31:0] E_A5  = 32'h14A;
  localparam logic [31:0] E_01M = 32'h003;
  localparam logic [31:0] E_01L = 32'h101;
  localparam logic [31:0] E_07  = 32'h00F;
  localparam logic [31:0] E_03  = 32'h006;
`else
  localparam int NB = W;
  localparam logic [31:0] E_B6  = 32'hB6;
  localparam logic [31:0] E_B2B = 32'h36F0;
  localparam logic [31:0] E_A5  = 32'hA5;
  localparam logic [31:0] E_01M = 32'h01;
  localparam logic [31:0] E_01L = 32'h80;
  localparam logic [31:0] E_07  = 32'h07;
  localparam logic [31:0] E_03  = 32'h03;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         stall = 1'b0;
  logic         d_m, dv_m, rdy_m, busy_m;
  logic         d_l, dv_l, rdy_l, busy_l;

  p2s_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .stall(stall), .data(d_m), .data_valid(dv_m), .busy(busy_m)
  );

  p2s_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .stall(stall), .data(d_l), .data_valid(dv_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted word appends its bits (in emission order) to a queue; every non-stalled edge pops one.
  bit   qm[$];
  bit   ql[$];
  logic exp_dm = 1'b0, exp_dl = 1'b0, exp_dv = 1'b0;
  bit   m_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      qm.delete();
      ql.delete();
      exp_dm = 1'b0;
      exp_dl = 1'b0;
      exp_dv = 1'b0;
    end
    m_rdy = (qm.size() == 0) || (qm.size() == 1 && !stall);
    check("dv_msb",    dv_m,   exp_dv);
    check("data_msb",  d_m,    exp_dm);
    check("dv_lsb",    dv_l,   exp_dv);
    check("data_lsb",  d_l,    exp_dl);
    check("ready_msb", rdy_m,  m_rdy);
    check("ready_lsb", rdy_l,  m_rdy);
    check("busy_msb",  busy_m, qm.size() != 0);
    check("busy_lsb",  busy_l, ql.size() != 0);
    if (rst_n) begin
      if (qm.size() != 0 && !stall) begin
        exp_dv = 1'b1;
        exp_dm = qm.pop_front();
        exp_dl = ql.pop_front();
      end else begin
        exp_dv = 1'b0;
      end
      if (din_valid && m_rdy) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back(din[W-1-i]);
          ql.push_back(din[i]);
        end
`ifdef P2S_PARITY_EN
        qm.push_back(^din);
        ql.push_back(^din);
`endif
      end
    end
  end

  // Directed-test helpers: inputs change only at posedge+1, outputs are sampled at negedge.
  logic [31:0] cap_m, cap_l;
  int          cap_n;
  bit          acc_s, busy_s;

  task automatic clear_cap();
    cap_m = '0;
    cap_l = '0;
    cap_n = 0;
  endtask

  task automatic step();
    @(negedge clk);
    acc_s  = din_valid && rdy_m;
    busy_s = busy_m;
    if (dv_m) begin
      cap_m = {cap_m[30:0], d_m};
      cap_l = {cap_l[30:0], d_l};
      cap_n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    din       = w;
    din_valid = 1'b1;
    acc_s     = 1'b0;
    for (int n = 0; n < 60 && !acc_s; n++) step();
    check("send_accepted", acc_s, 1);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    busy_s = 1'b1;
    for (int n = 0; n < 100 && busy_s; n++) step();
    check("drain_idle", busy_s, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; din = 8'hB6; din_valid = 1'b1; stall = 1'b0;
    #1;
    step();
    step();
    check("rst_dv",    dv_m,   0);
    check("rst_data",  d_m,    0);
    check("rst_busy",  busy_m, 0);
    check("rst_ready", rdy_m,  1);

    clear_cap();
    rst_n = 1'b1;
    step();
    check("first_accept", acc_s, 1);
    din_valid = 1'b0;
    drain();
    check("b6_bits",  cap_m, E_B6);
    check("b6_count", cap_n, NB);

    clear_cap();
    send(8'h36);
    send(8'hF0);
    drain();
    check("b2b_bits",  cap_m, E_B2B);
    check("b2b_count", cap_n, 2 * NB);

    clear_cap();
    send(8'hA5);
    step();
    step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    drain();
    check("stall_bits",  cap_m, E_A5);
    check("stall_count", cap_n, NB);

    clear_cap();
    send(8'h01);
    drain();
    check("w01_msb", cap_m, E_01M);
    check("w01_lsb", cap_l, E_01L);

    clear_cap();
    send(8'h07);
    drain();
    check("w07_bits", cap_m, E_07);

    clear_cap();
    send(8'h03);
    drain();
    check("w03_bits", cap_m, E_03);

    clear_cap();
    send(8'hFF);
    for (int n = 0; n < 20 && cap_n < 3; n++) step();
    check("mid_bits_seen", cap_n, 3);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_dv",   dv_m,   0);
    check("rst_async_busy", busy_m, 0);
    step();
    rst_n = 1'b1;
    clear_cap();
    repeat (12) step();
    check("no_bits_after_rst", cap_n, 0);

    for (int i = 0; i < 3000; i++) begin
      din_valid = ($urandom_range(0, 3) != 0);
      din       = W'($urandom);
      stall     = ($urandom_range(0, 4) == 0);
      if (i == 1500) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end
    din_valid = 1'b0;
    stall     = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
